// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: STAGES valid/ready slices with bubble collapse, sync flush and optional skid slot.
// Latency: STAGES cycles from input accept to out_valid when unstalled; 1 entry/cycle throughput.
// Backpressure: SKID=1 gives registered in_ready (skid absorbs one entry), SKID=0 gives in_ready combinational from out_ready.
// Optional: define PIPE_STAGE_STALL_CNT_EN to add the saturating 32-bit stall_cnt output.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 64,
  parameter int STAGES = 1,
  parameter int SKID   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CTRL_W-1:0]                     in_ctrl,
  input  logic [DATA_W-1:0]                     in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CTRL_W-1:0]                     out_ctrl,
  output logic [DATA_W-1:0]                     out_data,
`ifdef PIPE_STAGE_STALL_CNT_EN
  output logic [31:0]                           stall_cnt,
`endif
  output logic [$clog2(STAGES+SKID+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(STAGES + SKID + 1);

  // Slice state; slice STAGES-1 faces the downstream stage.
  logic [STAGES-1:0] vld_q;
  logic [CTRL_W-1:0] ctl_q [STAGES];
  logic [DATA_W-1:0] dat_q [STAGES];

  // adv[k]: slice k may load this cycle; adv[STAGES] is the downstream consume.
  logic [STAGES:0]   adv;

  // What each slice would load: slice 0 from the input side, others from the slice before.
  logic [STAGES-1:0] feed_vld;
  logic [CTRL_W-1:0] feed_ctl [STAGES];
  logic [DATA_W-1:0] feed_dat [STAGES];

  // Input-side source for slice 0 (skid slot first when present).
  logic              src_vld;
  logic [CTRL_W-1:0] src_ctl;
  logic [DATA_W-1:0] src_dat;
  logic              in_fire;
  logic              skid_cnt;
  logic [OCC_W-1:0]  occ;

  assign in_fire = in_valid && in_ready;

  // Advance chain: an empty slice always loads, a full one only if the next one moves.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end
  end

  if (SKID != 0) begin : g_skid
    logic              skid_vld_q;
    logic [CTRL_W-1:0] skid_ctl_q;
    logic [DATA_W-1:0] skid_dat_q;

    // Registered ready: only an empty skid slot can take an entry; flush and reset refuse input.
    assign in_ready = !skid_vld_q && !flush && !rst;
    assign src_vld  = skid_vld_q || in_fire;
    assign src_ctl  = skid_vld_q ? skid_ctl_q : in_ctrl;
    assign src_dat  = skid_vld_q ? skid_dat_q : in_data;
    assign skid_cnt = skid_vld_q;

    // Skid slot: catches an accepted entry that slice 0 cannot take, drains into slice 0 first.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_vld_q <= 1'b0;
        skid_ctl_q <= '0;
        skid_dat_q <= '0;
      end else if (flush) begin
        skid_vld_q <= 1'b0;
        skid_ctl_q <= '0;
      end else if (skid_vld_q) begin
        if (adv[0]) begin
          skid_vld_q <= 1'b0;
          skid_ctl_q <= '0;
        end
      end else if (in_fire && !adv[0]) begin
        skid_vld_q <= 1'b1;
        skid_ctl_q <= in_ctrl;
        skid_dat_q <= in_data;
      end
    end
  end else begin : g_noskid
    // Without a skid slot the input is only taken when slice 0 moves this cycle.
    assign in_ready = adv[0] && !flush && !rst;
    assign src_vld  = in_fire;
    assign src_ctl  = in_ctrl;
    assign src_dat  = in_data;
    assign skid_cnt = 1'b0;
  end

  // Feed selection: slice 0 takes the input side, slice k takes slice k-1.
  always_comb begin
    feed_vld[0] = src_vld;
    feed_ctl[0] = src_ctl;
    feed_dat[0] = src_dat;
    for (int k = 1; k < STAGES; k++) begin
      feed_vld[k] = vld_q[k-1];
      feed_ctl[k] = ctl_q[k-1];
      feed_dat[k] = dat_q[k-1];
    end
  end

  // Slice registers: load on advance, ctrl zeroed for bubbles, data only replaced by a real entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        ctl_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        ctl_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= feed_vld[k];
          ctl_q[k] <= feed_vld[k] ? feed_ctl[k] : '0;
          if (feed_vld[k]) begin
            dat_q[k] <= feed_dat[k];
          end
        end
      end
    end
  end

  // Occupancy is the population count of held entries, skid slot included.
  always_comb begin
    occ = OCC_W'(skid_cnt);
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(vld_q[k]);
    end
  end

  assign occupancy = occ;
  assign out_valid = vld_q[STAGES-1];
  assign out_ctrl  = ctl_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where a held output is refused downstream; saturates, survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (S2/skid, S3/skid, S1/no skid) driven with shared stimulus.
// Each configuration is checked every cycle against a queue-of-entries reference model.
module tb_pipe_stage_reg;
  localparam int CW   = 3;
  localparam int DW   = 64;
  localparam int NDUT = 3;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy_a, rdy_b, rdy_c;
  logic          ov_a, ov_b, ov_c;
  logic [CW-1:0] oc_a, oc_b, oc_c;
  logic [DW-1:0] od_a, od_b, od_c;
  logic [1:0]    occ_a;
  logic [2:0]    occ_b;
  logic [0:0]    occ_c;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0]   stall_a, stall_b, stall_c;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(2), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_ctrl(oc_a), .out_data(od_a),
`ifdef PIPE_STAGE_STALL_CNT_EN
    .stall_cnt(stall_a),
`endif
    .occupancy(occ_a));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(3), .SKID(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_ctrl(oc_b), .out_data(od_b),
`ifdef PIPE_STAGE_STALL_CNT_EN
    .stall_cnt(stall_b),
`endif
    .occupancy(occ_b));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(1), .SKID(0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
    .out_ctrl(oc_c), .out_data(od_c),
`ifdef PIPE_STAGE_STALL_CNT_EN
    .stall_cnt(stall_c),
`endif
    .occupancy(occ_c));

  // Model entry: pos is its rank toward the output (depth-1 = visible, -1 = waiting in skid).
  typedef struct packed {
    logic [CW-1:0]      ctrl;
    logic [DW-1:0]      data;
    logic signed [7:0]  pos;
  } ent_t;

  ent_t        q_a[$], q_b[$], q_c[$], w[$];
  int          checks   = 0;
  int          failures = 0;
  logic        exp_rdy[NDUT];
  logic        exp_ov[NDUT];
  logic [31:0] exp_stall;

  function automatic int depth(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 3 : 1;
  endfunction

  function automatic bit has_skid(input int sel);
    return sel != 2;
  endfunction

  function automatic string nm(input int sel);
    return (sel == 0) ? "A" : (sel == 1) ? "B" : "C";
  endfunction

  // what: 0 in_ready, 1 out_valid, 2 out_ctrl, 3 out_data, 4 occupancy
  function automatic logic [DW-1:0] obs(input int sel, input int what);
    logic [DW-1:0] r;
    r = '0;
    case (sel)
      0: case (what) 0: r = 64'(rdy_a); 1: r = 64'(ov_a); 2: r = 64'(oc_a); 3: r = od_a; default: r = 64'(occ_a); endcase
      1: case (what) 0: r = 64'(rdy_b); 1: r = 64'(ov_b); 2: r = 64'(oc_b); 3: r = od_b; default: r = 64'(occ_b); endcase
      default: case (what) 0: r = 64'(rdy_c); 1: r = 64'(ov_c); 2: r = 64'(oc_c); 3: r = od_c; default: r = 64'(occ_c); endcase
    endcase
    return r;
  endfunction

  task automatic pull(input int sel);
    case (sel)
      0: w = q_a;
      1: w = q_b;
      default: w = q_c;
    endcase
  endtask

  task automatic store(input int sel);
    case (sel)
      0: q_a = w;
      1: q_b = w;
      default: q_c = w;
    endcase
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Compare every DUT against its model before the edge and record the model's handshake view.
  task automatic pre_check();
    for (int s = 0; s < NDUT; s++) begin
      int   lim;
      int   np;
      logic ov;
      logic rdy;
      pull(s);
      ov = 1'b0;
      if (w.size() > 0) ov = (int'(w[0].pos) == depth(s) - 1);
      if (rst || flush) begin
        rdy = 1'b0;
      end else if (has_skid(s)) begin
        rdy = 1'b1;
        if (w.size() > 0) rdy = !(w[w.size()-1].pos < 0);
      end else begin
        lim = depth(s) - 1;
        for (int i = (ov && out_ready) ? 1 : 0; i < w.size(); i++) begin
          np  = (int'(w[i].pos) + 1 < lim) ? int'(w[i].pos) + 1 : lim;
          lim = np - 1;
        end
        rdy = (lim >= 0);
      end
      exp_rdy[s] = rdy;
      exp_ov[s]  = ov;
      chk($sformatf("%s.in_ready", nm(s)), obs(s, 0), 64'(rdy));
      chk($sformatf("%s.out_valid", nm(s)), obs(s, 1), 64'(ov));
      chk($sformatf("%s.out_ctrl", nm(s)), obs(s, 2), ov ? 64'(w[0].ctrl) : 64'd0);
      if (ov) chk($sformatf("%s.out_data", nm(s)), obs(s, 3), w[0].data);
      chk($sformatf("%s.occupancy", nm(s)), obs(s, 4), 64'(w.size()));
    end
  endtask

  // Apply this cycle's transfers to the models: pop, flush or push, then move entries forward.
  task automatic post_update();
    for (int s = 0; s < NDUT; s++) begin
      ent_t e;
      int   lim;
      int   np;
      pull(s);
      if (exp_ov[s] && out_ready) void'(w.pop_front());
      if (flush) begin
        w.delete();
      end else if (in_valid && exp_rdy[s]) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        e.pos  = -8'sd1;
        w.push_back(e);
      end
      lim = depth(s) - 1;
      for (int i = 0; i < w.size(); i++) begin
        e     = w[i];
        np    = (int'(e.pos) + 1 < lim) ? int'(e.pos) + 1 : lim;
        e.pos = 8'(np);
        w[i]  = e;
        lim   = np - 1;
      end
      store(s);
    end
    if (exp_ov[0] && !out_ready && (exp_stall != 32'hFFFF_FFFF)) exp_stall = exp_stall + 32'd1;
  endtask

  task automatic cyc();
    #1;
    pre_check();
    @(posedge clk);
    post_update();
    @(negedge clk);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("A.stall_cnt", 64'(stall_a), 64'(exp_stall));
`endif
  endtask

  task automatic drain();
    set_in(1'b0, '0, '0, 1'b1, 1'b1);
    cyc();
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
  endtask

  initial begin
    rst       = 1'b1;
    exp_stall = '0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset state
    #2;
    for (int s = 0; s < NDUT; s++) begin
      chk($sformatf("rst.%s.out_valid", nm(s)), obs(s, 1), 64'd0);
      chk($sformatf("rst.%s.out_ctrl", nm(s)), obs(s, 2), 64'd0);
      chk($sformatf("rst.%s.out_data", nm(s)), obs(s, 3), 64'd0);
      chk($sformatf("rst.%s.occupancy", nm(s)), obs(s, 4), 64'd0);
      chk($sformatf("rst.%s.in_ready", nm(s)), obs(s, 0), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1,2,3 through the 2-stage block
    set_in(1'b1, 3'b101, 64'd1, 1'b1, 1'b0); cyc();
    chk("t1.A.occ0", obs(0, 4), 64'd1);
    chk("t1.A.ov0", obs(0, 1), 64'd0);
    set_in(1'b1, 3'b101, 64'd2, 1'b1, 1'b0); cyc();
    chk("t1.A.ov1", obs(0, 1), 64'd1);
    chk("t1.A.data1", obs(0, 3), 64'd1);
    chk("t1.A.ctrl1", obs(0, 2), 64'b101);
    chk("t1.A.occ1", obs(0, 4), 64'd2);
    set_in(1'b1, 3'b101, 64'd3, 1'b1, 1'b0); cyc();
    chk("t1.A.data2", obs(0, 3), 64'd2);
    chk("t1.A.occ2", obs(0, 4), 64'd2);
    set_in(1'b0, '0, '0, 1'b1, 1'b0); cyc();
    chk("t1.A.data3", obs(0, 3), 64'd3);
    chk("t1.A.occ3", obs(0, 4), 64'd1);
    cyc();
    chk("t1.A.ov_end", obs(0, 1), 64'd0);
    drain();

    // Fill under backpressure so the third entry lands in the skid slot
    set_in(1'b1, 3'b001, 64'hA, 1'b0, 1'b0); cyc();
    set_in(1'b1, 3'b010, 64'hB, 1'b0, 1'b0); cyc();
    set_in(1'b1, 3'b011, 64'hC, 1'b0, 1'b0); cyc();
    chk("t2.A.occ_full", obs(0, 4), 64'd3);
    chk("t2.A.in_ready_full", obs(0, 0), 64'd0);
    chk("t2.A.head", obs(0, 3), 64'hA);
    set_in(1'b0, '0, '0, 1'b1, 1'b0); cyc();
    chk("t2.A.second", obs(0, 3), 64'hB);
    chk("t2.A.occ_2", obs(0, 4), 64'd2);
    cyc();
    chk("t2.A.third", obs(0, 3), 64'hC);
    chk("t2.A.ctrl3", obs(0, 2), 64'b011);
    cyc();
    chk("t2.A.empty", obs(0, 1), 64'd0);
    drain();

    // Flush with three entries in flight in the 3-stage block
    set_in(1'b1, 3'b011, 64'h31, 1'b1, 1'b0); cyc();
    set_in(1'b1, 3'b011, 64'h32, 1'b1, 1'b0); cyc();
    set_in(1'b1, 3'b011, 64'h33, 1'b1, 1'b0); cyc();
    chk("t3.B.occ3", obs(1, 4), 64'd3);
    set_in(1'b1, 3'b111, 64'h55, 1'b1, 1'b1);
    #1;
    chk("t3.B.in_ready_flush", obs(1, 0), 64'd0);
    cyc();
    chk("t3.B.ov_after", obs(1, 1), 64'd0);
    chk("t3.B.ctrl_after", obs(1, 2), 64'd0);
    chk("t3.B.occ_after", obs(1, 4), 64'd0);
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (4) cyc();
    chk("t3.B.no_0x55", obs(1, 1), 64'd0);
    drain();

    // No-skid block: in_ready follows out_ready while full
    set_in(1'b1, 3'b010, 64'h100, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 8; i++) begin
      logic ordy;
      ordy = (i % 2 == 0);
      set_in(1'b1, 3'b010, 64'h101 + 64'(i), ordy, 1'b0);
      #1;
      chk($sformatf("t4.C.in_ready_%0d", i), obs(2, 0), 64'(ordy));
      cyc();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cyc();
    drain();

    // Asynchronous reset mid-cycle with two entries held
    set_in(1'b1, 3'b001, 64'h71, 1'b0, 1'b0); cyc();
    set_in(1'b1, 3'b010, 64'h72, 1'b0, 1'b0); cyc();
    chk("t5.A.occ2", obs(0, 4), 64'd2);
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < NDUT; s++) begin
      chk($sformatf("t5.%s.out_valid", nm(s)), obs(s, 1), 64'd0);
      chk($sformatf("t5.%s.out_ctrl", nm(s)), obs(s, 2), 64'd0);
      chk($sformatf("t5.%s.out_data", nm(s)), obs(s, 3), 64'd0);
      chk($sformatf("t5.%s.occupancy", nm(s)), obs(s, 4), 64'd0);
      chk($sformatf("t5.%s.in_ready", nm(s)), obs(s, 0), 64'd0);
    end
    q_a.delete();
    q_b.delete();
    q_c.delete();
    exp_stall = '0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (4) cyc();

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter: counts refused cycles, survives flush, saturates
    set_in(1'b1, 3'b100, 64'h90, 1'b0, 1'b0); cyc();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (6) cyc();
    chk("t6.A.stall5", 64'(stall_a), 64'd5);
    set_in(1'b0, '0, '0, 1'b1, 1'b1); cyc();
    chk("t6.A.stall_flush", 64'(stall_a), 64'd5);
    force u_a.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_a.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFE;
    set_in(1'b1, 3'b100, 64'h91, 1'b0, 1'b0); cyc();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) cyc();
    chk("t6.A.stall_sat", 64'(stall_a), 64'hFFFF_FFFF);
    drain();
`endif

    // Random traffic, first with light then with heavy backpressure
    for (int i = 0; i < 600; i++) begin
      logic iv;
      logic ordy;
      logic fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 31) == 0);
      set_in(iv, CW'($urandom), {$urandom(), $urandom()}, ordy, fl);
      cyc();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
